payload_capture_buffer: RTL and testbench
=========================================

// Module: payload_capture_buffer
// PURPOSE
//  Downstream stage of the packet detector. Watches the detector's detect flag and
//  latches its payload length. It then captures exactly that many subsequent valid
//  complex samples (Q4.12) into an internal FIFO. It streams them out over a
//  valid/ready interface with a frame-last marker, feeding the payload demod stage.
// PARAMETERS
//  DATA_W      16    width of each I/Q component (Q4.12)
//  FIFO_DEPTH  64    capture FIFO entries; power of two, >= 2
//  MAX_LEN     4095  largest accepted payload length in samples
// PORTS
//  clk               in   1       system clock
//  rst_n             in   1       asynchronous reset, active-low
//  start_i           in   1       sync clear: abort frame, flush FIFO, clear flags
//  valid_i           in   1       input sample valid
//  r_i               in   DATA_W  real part, signed
//  i_i               in   DATA_W  imaginary part, signed
//  detect_i          in   1       detect flag from packet detector (level)
//  payload_length_i  in   16      signed payload length in samples, sampled on detect edge
//  m_valid_o         out  1       output sample valid
//  m_ready_i         in   1       downstream ready
//  m_r_o             out  DATA_W  output real part
//  m_i_o             out  DATA_W  output imaginary part
//  m_last_o          out  1       final sample of frame
//  busy_o            out  1       high in CAPTURE or DRAIN
//  frame_done_o      out  1       1-cycle pulse on the handshake of the last beat
//  len_err_o         out  1       1-cycle pulse: latched length <= 0 or > MAX_LEN
//  overflow_o        out  1       sticky: a sample was dropped on a full FIFO
// BEHAVIOUR
//  - Reset is asynchronous and active-low. On reset: state IDLE, FIFO empty, all outputs 0.
//  - m_r_o and m_i_o read 0 whenever m_valid_o = 0.
//  - detect_q is detect_i registered. A detect edge is detect_i & ~detect_q; it is evaluated in IDLE only.
//  - IDLE, detect edge, length L = payload_length_i:
//      - 1 <= L <= MAX_LEN: rem <= L, go to CAPTURE.
//      - Otherwise: pulse len_err_o and stay in IDLE.
//    The sample present in the detect-edge cycle is not captured.
//  - CAPTURE: each valid_i cycle decrements rem and pushes {r_i,i_i} when accepted.
//      - When rem goes 1 -> 0, go to DRAIN.
//  - Push acceptance: a push is accepted if count < FIFO_DEPTH, or if a pop fires in the same cycle.
//      - Otherwise the sample is dropped, overflow_o is set, and rem still decrements,
//        so frame length is preserved.
//  - FIFO: first-word fall-through, 1-cycle latency. A sample pushed at edge N is on the outputs
//    with m_valid_o = 1 after edge N. A pop fires when m_valid_o & m_ready_i.
//  - Beats stream out during CAPTURE; no waiting for frame end.
//  - DRAIN: no pushes. m_last_o = m_valid_o & (count == 1).
//      - On the last handshake: pulse frame_done_o, go to IDLE.
//  - If the FIFO is empty on DRAIN entry, go to IDLE with frame_done_o pulsed and no last beat.
//    This happens only if every sample was dropped.
//  - m_valid_o / data must stay stable while m_ready_i = 0. No beat is lost or duplicated.
//  - count: 0..FIFO_DEPTH, counter width clog2(FIFO_DEPTH)+1. rd/wr pointers wrap modulo FIFO_DEPTH.
//  - rem: 16-bit unsigned once validated.
//  - start_i, any state: next cycle is IDLE, FIFO empty, overflow_o = 0, rem = 0.
//      - start_i overrides detect, push and pop in the same cycle.
//  - detect_i toggling in CAPTURE or DRAIN is ignored. A new frame needs a fresh edge in IDLE.
//  - overflow_o clears only on start_i or reset.
// TESTING
//  1. L=4, 6 valid samples after edge, m_ready_i=1 -> first 4 out in order; last on 4th; frame_done pulses; samples 5-6 ignored.
//  2. L=0, then L=-3, then L=5000 -> len_err_o pulses each time; state stays IDLE; busy_o=0.
//  3. L=8, m_ready_i toggling 1010... -> all 8 beats intact and stable under backpressure; m_last_o only on beat 8.
//  4. FIFO_DEPTH=4, L=10, m_ready_i=0 during capture, then 1 -> 4 beats out; overflow_o=1; busy_o=0 after 4th beat.
//  5. L=6, assert start_i after 3 captured samples -> next cycle: IDLE, m_valid_o=0, no frame_done.
//  6. rst_n low mid-DRAIN (asynchronous, between edges) -> all outputs 0 immediately.
//     After release, a new L=2 frame outputs correctly.

Source files
------------

// File: rtl/payload_capture_buffer_if.sv
// Output sample stream of the payload capture buffer (valid/ready with frame-last).
//   m_valid : sample valid (source -> sink)
//   m_ready : sink ready   (sink -> source)
//   m_r/m_i : real / imaginary part, signed Q4.12
//   m_last  : final sample of the frame
interface payload_capture_buffer_if #(
  parameter int unsigned DATA_W = 16
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_r;
  logic [DATA_W-1:0] m_i;
  logic              m_last;

  modport master (output m_valid, m_r, m_i, m_last, input m_ready);
  modport slave  (input m_valid, m_r, m_i, m_last, output m_ready);
endinterface

// File: rtl/payload_capture_buffer.sv
// Payload capture buffer: on a detect edge latches the payload length, captures
// that many following valid I/Q samples into a FWFT FIFO and streams them out
// with a frame-last marker.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_i           : synchronous abort/flush, clears overflow
//   valid_i,r_i,i_i   : input sample stream
//   detect_i          : detector flag (level), edge-sensitive in IDLE
//   payload_length_i  : signed frame length, sampled on the detect edge
//   m_if              : output stream (valid/ready/data/last)
//   busy_o            : capture or drain in progress
//   frame_done_o      : pulse after the last beat handshake
//   len_err_o         : pulse after a detect edge with an out-of-range length
//   overflow_o        : sticky, a sample was dropped on a full FIFO
module payload_capture_buffer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_LEN    = 4095
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        r_i,
  input  logic [DATA_W-1:0]        i_i,
  input  logic                     detect_i,
  input  logic [15:0]              payload_length_i,
  payload_capture_buffer_if.master m_if,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     len_err_o,
  output logic                     overflow_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WORD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  state_e            state_q;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [15:0]       rem_q;
  logic              detect_q;
  logic              frame_done_q;
  logic              len_err_q;
  logic              overflow_q;

  logic              fifo_valid;
  logic              fifo_full;
  logic              pop;
  logic              cap_fire;
  logic              push;
  logic              detect_edge;
  logic signed [15:0] len_s;
  logic              len_ok;
  logic [WORD_W-1:0] head;

  // Handshake and capture qualifiers
  always_comb begin
    fifo_valid  = (count_q != '0);
    fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    pop         = fifo_valid & m_if.m_ready;
    cap_fire    = (state_q == CAPTURE) & valid_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    push        = cap_fire & (~fifo_full | pop);
    detect_edge = detect_i & ~detect_q;
    len_s       = $signed(payload_length_i);
    len_ok      = (len_s > 16'sd0) && (int'(len_s) <= int'(MAX_LEN));
    head        = mem_q[rd_ptr_q];
  end

  // Output stream; data forced to zero while nothing is valid
  always_comb begin
    m_if.m_valid = fifo_valid;
    m_if.m_r     = fifo_valid ? head[WORD_W-1:DATA_W] : '0;
    m_if.m_i     = fifo_valid ? head[DATA_W-1:0]      : '0;
    m_if.m_last  = fifo_valid & (state_q == DRAIN) & (count_q == CNT_W'(1));
    busy_o       = (state_q != IDLE);
    frame_done_o = frame_done_q;
    len_err_o    = len_err_q;
    overflow_o   = overflow_q;
  end

  // Sample storage; contents need no reset since reads are qualified by count
  always_ff @(posedge clk) begin
    if (push && !start_i) begin
      mem_q[wr_ptr_q] <= {r_i, i_i};
    end
  end

  // Control FSM, FIFO pointers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rem_q        <= '0;
      detect_q     <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      detect_q     <= detect_i;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      if (start_i) begin
        state_q    <= IDLE;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        rem_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        // Dropped samples still count against the frame length
        if (cap_fire && !push) overflow_q <= 1'b1;
        unique case (state_q)
          IDLE: begin
            if (detect_edge) begin
              if (len_ok) begin
                rem_q   <= payload_length_i;
                state_q <= CAPTURE;
              end else begin
                len_err_q <= 1'b1;
              end
            end
          end
          CAPTURE: begin
            if (valid_i) begin
              rem_q <= rem_q - 16'd1;
              if (rem_q == 16'd1) state_q <= DRAIN;
            end
          end
          DRAIN: begin
            // Empty on entry only when every sample was dropped
            if (!fifo_valid || (pop && (count_q == CNT_W'(1)))) begin
              state_q      <= IDLE;
              frame_done_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_payload_capture_buffer.sv
module tb_payload_capture_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, valid, detect;
  logic [15:0] r, im, len;
  logic        busy, fd, le, ovf;
  logic        busy4, fd4, le4, ovf4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  payload_capture_buffer_if #(.DATA_W(16)) mif ();
  payload_capture_buffer_if #(.DATA_W(16)) m4if ();

  payload_capture_buffer #(.DATA_W(16), .FIFO_DEPTH(64), .MAX_LEN(4095)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .valid_i(valid), .r_i(r), .i_i(im),
    .detect_i(detect), .payload_length_i(len), .m_if(mif.master),
    .busy_o(busy), .frame_done_o(fd), .len_err_o(le), .overflow_o(ovf));

  payload_capture_buffer #(.DATA_W(16), .FIFO_DEPTH(4), .MAX_LEN(4095)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .valid_i(valid), .r_i(r), .i_i(im),
    .detect_i(detect), .payload_length_i(len), .m_if(m4if.master),
    .busy_o(busy4), .frame_done_o(fd4), .len_err_o(le4), .overflow_o(ovf4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] samp(input int k);
    logic [15:0] a, b;
    a = 16'(k * 37 + 5);
    b = 16'(-(k * 11) - 1);
    return {a, b};
  endfunction

  function automatic logic [31:0] odata(input bit u4);
    return u4 ? {m4if.m_r, m4if.m_i} : {mif.m_r, mif.m_i};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Detect edge with length L, then stream nsamp samples; checks order, last, stability
  task automatic frame(input bit u4, input logic [15:0] L, input int nsamp, input int rmode,
                       input int exp_beats, input string nm);
    int beats = 0;
    bit done = 0, stall = 0, rdy, v, lst;
    logic [31:0] d, pd = '0;
    detect = 1'b1; len = L; valid = 1'b1; {r, im} = 32'hDEADBEEF;
    mif.m_ready = 1'b1; m4if.m_ready = 1'b1;
    @(posedge clk); #1;
    detect = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      valid = (c < nsamp);
      {r, im} = samp(c + 1);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = (c >= nsamp);
      endcase
      if (u4) m4if.m_ready = rdy; else mif.m_ready = rdy;
      v   = u4 ? m4if.m_valid : mif.m_valid;
      lst = u4 ? m4if.m_last : mif.m_last;
      d   = odata(u4);
      if (stall) begin
        chk({nm, " hold_valid"}, 32'(v), 32'd1);
        chk({nm, " hold_data"}, d, pd);
      end
      if (v && rdy) begin
        beats++;
        chk({nm, " beat_data"}, d, samp(beats));
        chk({nm, " beat_last"}, 32'(lst), 32'(beats == exp_beats));
      end
      stall = v && !rdy;
      pd = d;
      @(posedge clk); #1;
      if (u4 ? fd4 : fd) done = 1'b1;
    end
    valid = 1'b0; mif.m_ready = 1'b1; m4if.m_ready = 1'b1;
    chk({nm, " frame_done_seen"}, 32'(done), 32'd1);
    chk({nm, " beat_count"}, 32'(beats), 32'(exp_beats));
    chk({nm, " busy_after"}, 32'(u4 ? busy4 : busy), 32'd0);
    @(posedge clk); #1;
    chk({nm, " done_pulse_width"}, 32'(u4 ? fd4 : fd), 32'd0);
  endtask

  // Reference model of the depth-4 instance: queue of captured samples
  int          ms, mrem;
  logic [31:0] mq[$];
  bit          movf, mfd, mle, mdq;

  task automatic model_step();
    bit pop, acc;
    int sl;
    acc = 1'b0;
    if (start) begin
      ms = 0; mrem = 0; mq.delete(); movf = 0; mfd = 0; mle = 0;
    end else begin
      pop = (mq.size() > 0) && m4if.m_ready;
      mfd = 0; mle = 0;
      sl = int'($signed(len));
      case (ms)
        0: if (detect && !mdq) begin
             if (sl >= 1 && sl <= 4095) begin mrem = sl; ms = 1; end
             else mle = 1;
           end
        1: if (valid) begin
             acc = (mq.size() < 4) || pop;
             if (!acc) movf = 1;
             mrem--;
             if (mrem == 0) ms = 2;
           end
        default: if (mq.size() == 0 || (pop && mq.size() == 1)) begin ms = 0; mfd = 1; end
      endcase
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back({r, im});
    end
    mdq = detect;
  endtask

  typedef struct {
    logic        det;
    logic [15:0] ln;
    logic        vld;
    int          sk;
    logic        ev;
    int          esk;
    logic        el;
    logic        eb;
    logic        efd;
  } vec_t;

  typedef struct {
    logic [15:0] ln;
    logic        ele;
    logic        eb;
  } lv_t;

  initial begin
    vec_t t1[8];
    lv_t  t2[5];
    logic [31:0] ed;
    int k;

    t1[0] = '{1'b1, 16'd4, 1'b1, 99, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    t1[1] = '{1'b1, 16'd4, 1'b1, 1,  1'b1, 1, 1'b0, 1'b1, 1'b0};
    t1[2] = '{1'b1, 16'd4, 1'b1, 2,  1'b1, 2, 1'b0, 1'b1, 1'b0};
    t1[3] = '{1'b1, 16'd4, 1'b1, 3,  1'b1, 3, 1'b0, 1'b1, 1'b0};
    t1[4] = '{1'b1, 16'd4, 1'b1, 4,  1'b1, 4, 1'b1, 1'b1, 1'b0};
    t1[5] = '{1'b1, 16'd4, 1'b1, 5,  1'b0, 0, 1'b0, 1'b0, 1'b1};
    t1[6] = '{1'b0, 16'd4, 1'b1, 6,  1'b0, 0, 1'b0, 1'b0, 1'b0};
    t1[7] = '{1'b0, 16'd4, 1'b0, 7,  1'b0, 0, 1'b0, 1'b0, 1'b0};

    t2[0] = '{16'd0,    1'b1, 1'b0};
    t2[1] = '{16'hFFFD, 1'b1, 1'b0};
    t2[2] = '{16'd5000, 1'b1, 1'b0};
    t2[3] = '{16'd4096, 1'b1, 1'b0};
    t2[4] = '{16'd4095, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; valid = 1'b0; detect = 1'b0;
    r = '0; im = '0; len = '0;
    mif.m_ready = 1'b1; m4if.m_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(mif.m_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_data", odata(0), 32'd0);

    // Length 4 frame, 6 samples offered, table-driven per cycle
    for (int n = 0; n < 8; n++) begin
      detect = t1[n].det; len = t1[n].ln; valid = t1[n].vld; {r, im} = samp(t1[n].sk);
      @(posedge clk); #1;
      ed = t1[n].ev ? samp(t1[n].esk) : 32'd0;
      chk($sformatf("t1[%0d] valid", n), 32'(mif.m_valid), 32'(t1[n].ev));
      chk($sformatf("t1[%0d] data", n), odata(0), ed);
      chk($sformatf("t1[%0d] last", n), 32'(mif.m_last), 32'(t1[n].el));
      chk($sformatf("t1[%0d] busy", n), 32'(busy), 32'(t1[n].eb));
      chk($sformatf("t1[%0d] done", n), 32'(fd), 32'(t1[n].efd));
    end
    valid = 1'b0;

    // Length range checks
    for (int n = 0; n < 5; n++) begin
      detect = 1'b1; len = t2[n].ln;
      @(posedge clk); #1;
      chk($sformatf("t2[%0d] len_err", n), 32'(le), 32'(t2[n].ele));
      chk($sformatf("t2[%0d] busy", n), 32'(busy), 32'(t2[n].eb));
      detect = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("t2[%0d] len_err_clr", n), 32'(le), 32'd0);
      chk($sformatf("t2[%0d] busy2", n), 32'(busy), 32'(t2[n].eb));
      if (t2[n].eb) begin
        pulse_start();
        chk($sformatf("t2[%0d] abort", n), 32'(busy), 32'd0);
      end
    end

    // Backpressure 1010...
    pulse_start();
    frame(1'b0, 16'd8, 8, 1, 8, "t3");

    // Overflow on the depth-4 instance
    pulse_start();
    chk("t4 ovf_cleared", 32'(ovf4), 32'd0);
    frame(1'b1, 16'd10, 10, 2, 4, "t4");
    chk("t4 overflow", 32'(ovf4), 32'd1);

    // Abort mid-capture
    detect = 1'b1; len = 16'd6; valid = 1'b0;
    @(posedge clk); #1;
    detect = 1'b0; mif.m_ready = 1'b0; m4if.m_ready = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      valid = 1'b1; {r, im} = samp(n);
      @(posedge clk); #1;
    end
    chk("t5 busy_before", 32'(busy), 32'd1);
    chk("t5 valid_before", 32'(mif.m_valid), 32'd1);
    chk("t5 ovf4_before", 32'(ovf4), 32'd1);
    start = 1'b1; valid = 1'b1; {r, im} = samp(4);
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0; mif.m_ready = 1'b1; m4if.m_ready = 1'b1;
    chk("t5 valid", 32'(mif.m_valid), 32'd0);
    chk("t5 data", odata(0), 32'd0);
    chk("t5 busy", 32'(busy), 32'd0);
    chk("t5 done", 32'(fd), 32'd0);
    chk("t5 ovf4_cleared", 32'(ovf4), 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("t5 no_done", 32'(fd), 32'd0);
      chk("t5 idle_valid", 32'(mif.m_valid), 32'd0);
    end

    // Asynchronous reset while draining
    pulse_start();
    detect = 1'b1; len = 16'd4;
    @(posedge clk); #1;
    detect = 1'b0; mif.m_ready = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      valid = 1'b1; {r, im} = samp(n);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    chk("t6 busy_drain", 32'(busy), 32'd1);
    chk("t6 head", odata(0), samp(1));
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async_valid", 32'(mif.m_valid), 32'd0);
    chk("t6 async_data", odata(0), 32'd0);
    chk("t6 async_last", 32'(mif.m_last), 32'd0);
    chk("t6 async_busy", 32'(busy), 32'd0);
    chk("t6 async_flags", {29'd0, fd, le, ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mif.m_ready = 1'b1;
    @(posedge clk); #1;
    frame(1'b0, 16'd2, 2, 0, 2, "t6");

    // Randomized run on the depth-4 instance against the queue model
    pulse_start();
    ms = 0; mrem = 0; mq.delete(); movf = 0; mfd = 0; mle = 0; mdq = detect;
    for (int c = 0; c < 3000; c++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 6)      len = 16'($urandom_range(1, 12));
      else if (k == 7) len = 16'd0;
      else if (k == 8) len = 16'(-int'($urandom_range(1, 100)));
      else             len = 16'd5000;
      detect = ($urandom_range(0, 5) == 0);
      valid  = ($urandom_range(0, 3) != 0);
      {r, im} = 32'($urandom);
      start  = ($urandom_range(0, 299) == 0);
      m4if.m_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      model_step();
      @(posedge clk); #1;
      ed = (mq.size() > 0) ? mq[0] : 32'd0;
      chk("rnd valid", 32'(m4if.m_valid), 32'(mq.size() > 0));
      chk("rnd data", odata(1), ed);
      chk("rnd last", 32'(m4if.m_last), 32'(ms == 2 && mq.size() == 1));
      chk("rnd busy", 32'(busy4), 32'(ms != 0));
      chk("rnd done", 32'(fd4), 32'(mfd));
      chk("rnd len_err", 32'(le4), 32'(mle));
      chk("rnd overflow", 32'(ovf4), 32'(movf));
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
